pipeline_ex_muldiv: RTL and testbench

//  Multi-cycle M-extension execute unit beside the single-cycle EX ALU. Runs MUL/MULH/DIV/REM
//  (incl. word forms) with an iterative shift-add multiplier and a restoring divider.

---
 rtl/pipeline_ex_muldiv.sv | 199 +++++++++++++++++++
 tb/tb_pipeline_ex_muldiv.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ex_muldiv.sv
// Multi-cycle M-extension execute unit: iterative shift-add multiplier and restoring
// divider behind valid/ready handshakes, with RISC-V divide-by-zero/overflow results.
module pipeline_ex_muldiv #(
   parameter int DATA_WIDTH = 64,
   parameter int MUL_BITS   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            op,
   input  logic [2:0]            unsigned_op,
   input  logic                  is_word_op,
   input  logic [DATA_WIDTH-1:0] r1_val,
   input  logic [DATA_WIDTH-1:0] operand2,
   input  logic [4:0]            dst_reg,
   output logic                  out_valid,
   input  logic                  next_stage_ready,
   output logic [DATA_WIDTH-1:0] ex_res,
   output logic [4:0]            mem_dst_reg,
   output logic                  busy
);

   localparam int DW = DATA_WIDTH;
   localparam int CW = $clog2(DW) + 1;
   localparam logic [1:0] OP_MUL  = 2'd0;
   localparam logic [1:0] OP_MULH = 2'd1;
   localparam logic [1:0] OP_DIV  = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t            state_reg;
   logic [CW-1:0]     count_reg;
   logic [CW-1:0]     last_reg;
   logic [1:0]        op_reg;
   logic              word_reg;
   logic              neg_reg;
   logic [2*DW-1:0]   mcand_reg;
   logic [DW-1:0]     mplier_reg;
   logic [2*DW-1:0]   prod_reg;
   logic [DW-1:0]     quo_reg;
   logic [DW-1:0]     rem_reg;
   logic [DW-1:0]     dvs_reg;

   function automatic logic [DW-1:0] word_fix(input logic [DW-1:0] v, input logic w);
      return w ? {{(DW-32){v[31]}}, v[31:0]} : v;
   endfunction

   // Operand decode at accept time
   logic            word_eff, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
   logic [DW-1:0]   a_ext, b_ext, a_mag, b_mag, min_val, fast_res;
   logic [CW-1:0]   n_mul, n_div;

   always_comb begin
      word_eff = is_word_op && (op != OP_MULH);
      a_signed = (unsigned_op == 3'd0) || (unsigned_op == 3'd2);
      b_signed = (unsigned_op == 3'd0) || ((unsigned_op == 3'd2) && op[1]);
      if (word_eff) begin
         a_ext   = a_signed ? {{(DW-32){r1_val[31]}}, r1_val[31:0]}
                            : {{(DW-32){1'b0}}, r1_val[31:0]};
         b_ext   = b_signed ? {{(DW-32){operand2[31]}}, operand2[31:0]}
                            : {{(DW-32){1'b0}}, operand2[31:0]};
         min_val = {{(DW-31){1'b1}}, 31'd0};
         n_mul   = CW'(32 / MUL_BITS - 1);
         n_div   = CW'(31);
      end else begin
         a_ext   = r1_val;
         b_ext   = operand2;
         min_val = {1'b1, {(DW-1){1'b0}}};
         n_mul   = CW'(DW / MUL_BITS - 1);
         n_div   = CW'(DW - 1);
      end
      a_neg    = a_signed && a_ext[DW-1];
      b_neg    = b_signed && b_ext[DW-1];
      a_mag    = a_neg ? -a_ext : a_ext;
      b_mag    = b_neg ? -b_ext : b_ext;
      div_zero = (b_ext == '0);
      div_ovf  = a_signed && b_signed && (a_ext == min_val) && (b_ext == '1);
      if (div_zero) fast_res = (op == OP_DIV) ? '1 : a_ext;
      else          fast_res = (op == OP_DIV) ? min_val : '0;
   end

   // Multiplier step: one MUL_BITS-wide digit of partial products per cycle
   logic [2*DW-1:0] pp [MUL_BITS];
   logic [2*DW-1:0] prod_next, mul_signed;
   logic [DW-1:0]   mul_final;

   generate
      for (genvar gi = 0; gi < MUL_BITS; gi++) begin : g_pp
         assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
      end
   endgenerate

   always_comb begin
      prod_next = prod_reg;
      for (int i = 0; i < MUL_BITS; i++) prod_next = prod_next + pp[i];
      mul_signed = neg_reg ? -prod_next : prod_next;
      mul_final  = word_fix((op_reg == OP_MULH) ? mul_signed[2*DW-1:DW] : mul_signed[DW-1:0],
                            word_reg);
   end

   // Restoring divider step; the dividend MSB is always at quo_reg[DW-1]
   logic [DW:0]   div_sh, div_diff;
   logic [DW-1:0] rem_next, quo_next, div_raw, div_final;

   always_comb begin
      div_sh   = {rem_reg, quo_reg[DW-1]};
      div_diff = div_sh - {1'b0, dvs_reg};
      rem_next = div_diff[DW] ? div_sh[DW-1:0] : div_diff[DW-1:0];
      quo_next = {quo_reg[DW-2:0], ~div_diff[DW]};
      div_raw  = (op_reg == OP_DIV) ? quo_next : rem_next;
      div_final = word_fix(neg_reg ? -div_raw : div_raw, word_reg);
   end

   assign in_ready = (state_reg == S_IDLE) && !flush;
   assign busy     = (state_reg != S_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= S_IDLE;
         count_reg   <= '0;
         last_reg    <= '0;
         op_reg      <= OP_MUL;
         word_reg    <= 1'b0;
         neg_reg     <= 1'b0;
         mcand_reg   <= '0;
         mplier_reg  <= '0;
         prod_reg    <= '0;
         quo_reg     <= '0;
         rem_reg     <= '0;
         dvs_reg     <= '0;
         out_valid   <= 1'b0;
         ex_res      <= '0;
         mem_dst_reg <= '0;
      end else if (flush) begin
         state_reg <= S_IDLE;
         count_reg <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: if (in_valid) begin
               mem_dst_reg <= dst_reg;
               op_reg      <= op;
               word_reg    <= word_eff;
               count_reg   <= '0;
               if (!op[1]) begin
                  mcand_reg  <= {{DW{1'b0}}, a_mag};
                  mplier_reg <= b_mag;
                  prod_reg   <= '0;
                  neg_reg    <= a_neg ^ b_neg;
                  last_reg   <= n_mul;
                  state_reg  <= S_MUL;
               end else if (div_zero || div_ovf) begin
                  ex_res    <= word_fix(fast_res, word_eff);
                  out_valid <= 1'b1;
                  state_reg <= S_DONE;
               end else begin
                  quo_reg   <= word_eff ? (a_mag << (DW - 32)) : a_mag;
                  rem_reg   <= '0;
                  dvs_reg   <= b_mag;
                  neg_reg   <= (op == OP_DIV) ? (a_neg ^ b_neg) : a_neg;
                  last_reg  <= n_div;
                  state_reg <= S_DIV;
               end
            end
            S_MUL: begin
               mcand_reg  <= mcand_reg << MUL_BITS;
               mplier_reg <= mplier_reg >> MUL_BITS;
               prod_reg   <= prod_next;
               count_reg  <= count_reg + 1'b1;
               if (count_reg == last_reg) begin
                  ex_res    <= mul_final;
                  out_valid <= 1'b1;
                  count_reg <= '0;
                  state_reg <= S_DONE;
               end
            end
            S_DIV: begin
               quo_reg   <= quo_next;
               rem_reg   <= rem_next;
               count_reg <= count_reg + 1'b1;
               if (count_reg == last_reg) begin
                  ex_res    <= div_final;
                  out_valid <= 1'b1;
                  count_reg <= '0;
                  state_reg <= S_DONE;
               end
            end
            S_DONE: if (next_stage_ready) begin
               out_valid <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_ex_muldiv.sv
// Scoreboard bench for pipeline_ex_muldiv: directed vectors push expected results,
// a negedge monitor compares value, tag and first-valid cycle.
module tb_pipeline_ex_muldiv;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  op = 2'd0;
   logic [2:0]  unsigned_op = 3'd0;
   logic        is_word_op = 1'b0;
   logic [63:0] r1_val = '0;
   logic [63:0] operand2 = '0;
   logic [4:0]  dst_reg = '0;
   logic        out_valid;
   logic        next_stage_ready = 1'b1;
   logic [63:0] ex_res;
   logic [4:0]  mem_dst_reg;
   logic        busy;

   pipeline_ex_muldiv #(.DATA_WIDTH(64), .MUL_BITS(4)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .unsigned_op(unsigned_op), .is_word_op(is_word_op), .r1_val(r1_val),
      .operand2(operand2), .dst_reg(dst_reg), .out_valid(out_valid),
      .next_stage_ready(next_stage_ready), .ex_res(ex_res), .mem_dst_reg(mem_dst_reg),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] res;
      logic [4:0]  tag;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   bit   seen_valid = 1'b0;
   bit   any_valid = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: compare at the first cycle of each out_valid assertion
   always @(negedge clk) begin
      if (out_valid) any_valid = 1'b1;
      if (out_valid && !seen_valid) begin
         exp_t e;
         seen_valid = 1'b1;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=%h required=none", ex_res);
         end else begin
            e = exp_q.pop_front();
            $display("txn tag=%0d ex_res=%h cycle=%0d", mem_dst_reg, ex_res, cyc);
            check("result", ex_res, e.res);
            check("tag", 64'(mem_dst_reg), 64'(e.tag));
            check("latency", 64'(cyc), 64'(e.cyc));
         end
      end
      if (!out_valid) seen_valid = 1'b0;
   end

   task automatic do_op(input logic [1:0] o, input logic [2:0] u, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                        input logic [63:0] res, input int lat, input bit push, output int t0);
      int k = 0;
      @(negedge clk);
      while (!in_ready && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=0 required=1");
      end
      op = o; unsigned_op = u; is_word_op = w; r1_val = a; operand2 = b; dst_reg = tag;
      in_valid = 1'b1;
      t0 = cyc;
      if (push) exp_q.push_back('{res: res, tag: tag, cyc: t0 + lat});
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int t0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      check("rst_ex_res", ex_res, 64'd0);
      check("rst_tag", 64'(mem_dst_reg), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // op, unsigned_op, word, r1, op2, tag, expected, latency
      do_op(2'd0, 3'd0, 1'b0, 64'd7, -64'sd3, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, 17, 1'b1, t0); drain();
      do_op(2'd1, 3'd1, 1'b0, '1, '1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 17, 1'b1, t0); drain();
      do_op(2'd1, 3'd2, 1'b0, '1, 64'd2, 5'd3, '1, 17, 1'b1, t0); drain();
      do_op(2'd1, 3'd0, 1'b0, '1, '1, 5'd4, 64'd0, 17, 1'b1, t0); drain();
      do_op(2'd0, 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE, 9, 1'b1, t0); drain();
      do_op(2'd2, 3'd0, 1'b0, -64'sd20, 64'd3, 5'd6, 64'hFFFF_FFFF_FFFF_FFFA, 65, 1'b1, t0); drain();
      do_op(2'd3, 3'd0, 1'b0, -64'sd20, 64'd3, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b1, t0); drain();
      do_op(2'd2, 3'd0, 1'b1, 64'h8000_0000, '1, 5'd8, 64'hFFFF_FFFF_8000_0000, 1, 1'b1, t0); drain();
      do_op(2'd2, 3'd0, 1'b1, 64'hFFFF_FFF9, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1'b1, t0); drain();
      do_op(2'd3, 3'd1, 1'b1, 64'hFFFF_FFFF, 64'd10, 5'd10, 64'd5, 33, 1'b1, t0); drain();
      do_op(2'd2, 3'd1, 1'b0, 64'd100, 64'd0, 5'd11, '1, 1, 1'b1, t0); drain();
      do_op(2'd3, 3'd1, 1'b0, 64'd100, 64'd0, 5'd12, 64'd100, 1, 1'b1, t0); drain();
      do_op(2'd3, 3'd0, 1'b1, 64'd5, 64'd0, 5'd13, 64'd5, 1, 1'b1, t0); drain();
      do_op(2'd2, 3'd0, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd14, 64'h8000_0000_0000_0000, 1, 1'b1, t0); drain();
      do_op(2'd3, 3'd0, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd15, 64'd0, 1, 1'b1, t0); drain();

      // Output back-pressure: result must hold while MEM stalls
      next_stage_ready = 1'b0;
      do_op(2'd2, 3'd1, 1'b0, 64'd100, 64'd0, 5'd16, '1, 1, 1'b1, t0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_res", ex_res, '1);
         check("hold_tag", 64'(mem_dst_reg), 64'd16);
         check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      next_stage_ready = 1'b1;
      @(negedge clk);
      check("release_valid", 64'(out_valid), 64'd0);
      check("release_in_ready", 64'(in_ready), 64'd1);
      drain();

      // Flush during divide iteration 10
      do_op(2'd2, 3'd0, 1'b0, 64'd1000, 64'd7, 5'd17, '0, 0, 1'b0, t0);
      while (cyc < t0 + 10) @(negedge clk);
      any_valid = 1'b0;
      flush = 1'b1;
      #1;
      check("flush_in_ready_low", 64'(in_ready), 64'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_in_ready", 64'(in_ready), 64'd1);
      check("flush_busy", 64'(busy), 64'd0);
      repeat (70) @(negedge clk);
      check("flush_no_result", 64'(any_valid), 64'd0);
      do_op(2'd2, 3'd0, 1'b0, -64'sd20, 64'd3, 5'd18, 64'hFFFF_FFFF_FFFF_FFFA, 65, 1'b1, t0); drain();

      // Asynchronous reset in the middle of a multiply
      do_op(2'd0, 3'd0, 1'b0, 64'd9, 64'd9, 5'd19, '0, 0, 1'b0, t0);
      repeat (4) @(negedge clk);
      check("pre_reset_busy", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_ex_res", ex_res, 64'd0);
      check("arst_tag", 64'(mem_dst_reg), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      do_op(2'd3, 3'd0, 1'b1, 64'd5, 64'd0, 5'd20, 64'd5, 1, 1'b1, t0); drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
